// File: rtl/vedio_pkg.sv
// vedio_pkg
// Shared definitions for the video sequence controller and its optional
// frame geometry checker: the sequencer state encoding, the width of the
// source-select bus, default frame geometry and a helper that sizes counters.
// No ports; imported with "import vedio_pkg::*;".
package vedio_pkg;

  // Sequencer states, shared so the controller and any observer agree on encoding.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    WAIT_VS = 3'd2,
    RUN     = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5,
    TOUT    = 3'd6
  } seq_state_t;

  // Source select covers up to four source images.
  localparam int SRC_SEL_W = 2;

  // Default frame geometry and sequencing constants.
  localparam int DEFAULT_IW          = 640;
  localparam int DEFAULT_IH          = 480;
  localparam int DEFAULT_SRC_NUM     = 4;
  localparam int DEFAULT_FRM_PER_SRC = 2;
  localparam int DEFAULT_RST_CLK     = 16;
  localparam int DEFAULT_TIMEOUT_CLK = 1_000_000;

  // Number of bits needed to hold values 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vedio_frame_chk.sv
// vedio_frame_chk
// Measures the geometry of one processed frame while the sequencer is in RUN
// and raises a sticky error if any line is not IW pixels wide or the frame is
// not IH lines tall. Only instantiated when VEDIO_SEQ_FRAME_CHECK_EN is defined.
// Ports:
//   clk        in  pixel clock
//   rst_n      in  asynchronous active-low reset
//   run        in  sequencer is in RUN (frame in progress)
//   check      in  sequencer is in NEXT (frame just ended, evaluate it)
//   dst_hsync  in  processed-line valid
//   frame_err  out sticky geometry mismatch flag
module vedio_frame_chk
  import vedio_pkg::*;
#(
  parameter int IW = DEFAULT_IW,
  parameter int IH = DEFAULT_IH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic check,
  input  logic dst_hsync,
  output logic frame_err
);

  localparam int PCW = cnt_width(IW + 1);
  localparam int LCW = cnt_width(IH + 1);
  localparam logic [PCW-1:0] PIX_EXP  = PCW'(IW);
  localparam logic [PCW-1:0] PIX_SAT  = PCW'(IW + 1);
  localparam logic [LCW-1:0] LINE_EXP = LCW'(IH);
  localparam logic [LCW-1:0] LINE_SAT = LCW'(IH + 1);

  logic           hs_prev_q, hs_prev_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic           line_bad_q, line_bad_d;
  logic           frame_err_q, frame_err_d;
  logic           hs_rise, hs_fall;

  assign hs_rise = dst_hsync & ~hs_prev_q;
  assign hs_fall = ~dst_hsync & hs_prev_q;

  // While a frame runs, count lines on hsync rising edges and pixels on
  // hsync-high cycles; both saturate one past the expected value so an
  // oversized frame can never wrap back to a "correct" count. Each line's
  // width is judged when its hsync falls. On the check cycle the totals are
  // folded into the sticky error; outside RUN/NEXT the per-frame counters
  // are held clear, ready for the next frame.
  always_comb begin
    hs_prev_d   = dst_hsync;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_bad_d  = line_bad_q;
    frame_err_d = frame_err_q;
    if (run) begin
      if (hs_rise && (line_cnt_q != LINE_SAT)) begin
        line_cnt_d = line_cnt_q + LCW'(1);
      end
      if (dst_hsync) begin
        if (pix_cnt_q != PIX_SAT) begin
          pix_cnt_d = pix_cnt_q + PCW'(1);
        end
      end else if (hs_fall) begin
        if (pix_cnt_q != PIX_EXP) begin
          line_bad_d = 1'b1;
        end
        pix_cnt_d = '0;
      end
    end else if (check) begin
      // A line still open when vsync dropped is judged on what was seen.
      if (line_bad_q || (line_cnt_q != LINE_EXP) ||
          ((pix_cnt_q != '0) && (pix_cnt_q != PIX_EXP))) begin
        frame_err_d = 1'b1;
      end
    end else begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      line_bad_d = 1'b0;
    end
  end

  // Checker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_q   <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_bad_q  <= line_bad_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

endmodule

// File: rtl/vedio_seq_ctrl.sv
// vedio_seq_ctrl
// Sequences a video processing pipeline through SRC_NUM source images,
// capturing FRM_PER_SRC frames from each. Every source switch holds the
// pipeline in reset for RST_CLK cycles; a watchdog stops the sequence if no
// dst_vsync edge is seen for TIMEOUT_CLK cycles while waiting for or
// receiving a frame.
// Optional feature: define VEDIO_SEQ_FRAME_CHECK_EN to add the frame geometry
// checker (vedio_frame_chk); otherwise frame_err is tied low.
// Ports:
//   clk         in  pixel clock
//   rst_n       in  asynchronous active-low reset
//   start       in  one-cycle run request (honoured in IDLE and DONE only)
//   dst_vsync   in  processed-frame valid
//   dst_hsync   in  processed-line valid
//   src_sel     out source/file select
//   dut_rst_n   out pipeline reset, low while switching sources
//   busy        out sequence running
//   frame_done  out one-cycle frame-complete pulse
//   all_done    out sequence finished (held until restart)
//   timeout     out watchdog fired (held until reset)
//   frame_err   out sticky geometry mismatch (checker builds only)
module vedio_seq_ctrl
  import vedio_pkg::*;
#(
  parameter int IW          = DEFAULT_IW,
  parameter int IH          = DEFAULT_IH,
  parameter int SRC_NUM     = DEFAULT_SRC_NUM,
  parameter int FRM_PER_SRC = DEFAULT_FRM_PER_SRC,
  parameter int RST_CLK     = DEFAULT_RST_CLK,
  parameter int TIMEOUT_CLK = DEFAULT_TIMEOUT_CLK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dst_vsync,
  input  logic                 dst_hsync,
  output logic [SRC_SEL_W-1:0] src_sel,
  output logic                 dut_rst_n,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 all_done,
  output logic                 timeout,
  output logic                 frame_err
);

  localparam int FCW = cnt_width(FRM_PER_SRC);
  localparam int RCW = cnt_width(RST_CLK);
  localparam int WCW = cnt_width(TIMEOUT_CLK);
  localparam logic [FCW-1:0]       FRM_LAST = FCW'(FRM_PER_SRC);
  localparam logic [SRC_SEL_W-1:0] SRC_LAST = SRC_SEL_W'(SRC_NUM - 1);
  localparam logic [RCW-1:0]       RST_LAST = RCW'(RST_CLK - 1);
  localparam logic [WCW-1:0]       WD_LAST  = WCW'(TIMEOUT_CLK - 1);

  seq_state_t           state_q, state_d;
  logic [SRC_SEL_W-1:0] src_sel_q, src_sel_d;
  logic [FCW-1:0]       frm_cnt_q, frm_cnt_d;
  logic [FCW-1:0]       frm_inc;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [WCW-1:0]       wd_cnt_q, wd_cnt_d;
  logic                 vs_prev_q, vs_prev_d;
  logic                 dut_rst_n_q, dut_rst_n_d;
  logic                 vs_rise, vs_fall;

  assign vs_rise = dst_vsync & ~vs_prev_q;
  assign vs_fall = ~dst_vsync & vs_prev_q;

  // Next-state logic. Frames are delimited purely by vsync edges, so a frame
  // already in flight when WAIT_VS is entered (vsync high) produces no rising
  // edge there and is skipped until the following one. The reset and
  // watchdog counters default to zero so they restart on every state change
  // and on every vsync edge; they only advance while staying in their state.
  always_comb begin
    state_d   = state_q;
    src_sel_d = src_sel_q;
    frm_cnt_d = frm_cnt_q;
    rst_cnt_d = '0;
    wd_cnt_d  = '0;
    vs_prev_d = dst_vsync;
    frm_inc   = frm_cnt_q + FCW'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RST;
          src_sel_d = '0;
          frm_cnt_d = '0;
        end
      end
      RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = WAIT_VS;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = RUN;
        end else if (!vs_fall) begin
          if (wd_cnt_q == WD_LAST) begin
            state_d = TOUT;
          end else begin
            wd_cnt_d = wd_cnt_q + WCW'(1);
          end
        end
      end
      RUN: begin
        if (vs_fall) begin
          state_d = NEXT;
        end else if (!vs_rise) begin
          if (wd_cnt_q == WD_LAST) begin
            state_d = TOUT;
          end else begin
            wd_cnt_d = wd_cnt_q + WCW'(1);
          end
        end
      end
      NEXT: begin
        if (frm_inc < FRM_LAST) begin
          frm_cnt_d = frm_inc;
          state_d   = WAIT_VS;
        end else if (src_sel_q < SRC_LAST) begin
          src_sel_d = src_sel_q + SRC_SEL_W'(1);
          frm_cnt_d = '0;
          state_d   = RST;
        end else begin
          frm_cnt_d = frm_inc;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = RST;
          src_sel_d = '0;
          frm_cnt_d = '0;
        end
      end
      TOUT: begin
        state_d = TOUT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered from the next state so the pipeline reset lines up exactly
    // with the cycles spent in RST and still reads low while rst_n is low.
    dut_rst_n_d = (state_d != RST);
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_sel_q   <= '0;
      frm_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      vs_prev_q   <= 1'b0;
      dut_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_sel_q   <= src_sel_d;
      frm_cnt_q   <= frm_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      vs_prev_q   <= vs_prev_d;
      dut_rst_n_q <= dut_rst_n_d;
    end
  end

  assign src_sel    = src_sel_q;
  assign dut_rst_n  = dut_rst_n_q;
  assign busy       = (state_q == RST) || (state_q == WAIT_VS) ||
                      (state_q == RUN) || (state_q == NEXT);
  assign frame_done = (state_q == NEXT);
  assign all_done   = (state_q == DONE);
  assign timeout    = (state_q == TOUT);

`ifdef VEDIO_SEQ_FRAME_CHECK_EN
  logic in_run, in_next;
  assign in_run  = (state_q == RUN);
  assign in_next = (state_q == NEXT);

  vedio_frame_chk #(
    .IW (IW),
    .IH (IH)
  ) u_frame_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (in_run),
    .check     (in_next),
    .dst_hsync (dst_hsync),
    .frame_err (frame_err)
  );
`else
  // Geometry inputs have no consumer without the checker.
  localparam int unused_geom = IW + IH;
  logic unused_hsync;
  assign unused_hsync = dst_hsync;
  assign frame_err    = 1'b0;
`endif

endmodule
